// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the ID/EX operand stage and the ALU.
// The master side is whoever drives decode-side inputs and consumes the
// registered operands; the slave side is the operand stage itself.
interface id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  // Decode-side handshake and instruction fields
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       imm;
  logic                  sel_a_pc;
  logic                  sel_b_imm;
  logic [3:0]            alu_control_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  reg_write_in;

  // Downstream pipeline state used for forwarding and hazard detection
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic                  ex_mem_reg_write;
  logic                  mem_wb_reg_write;
  logic                  ex_mem_is_load;
  logic [XLEN-1:0]       ex_mem_result;
  logic [XLEN-1:0]       mem_wb_result;

  logic                  flush;

  // ALU-side handshake and registered operands
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       alu_in_a;
  logic [XLEN-1:0]       alu_in_b;
  logic [3:0]            alu_control_out;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  reg_write_out;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, pc, imm,
           sel_a_pc, sel_b_imm, alu_control_in, rd_in, reg_write_in,
           ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
           ex_mem_is_load, ex_mem_result, mem_wb_result, flush, out_ready,
    input  in_ready, out_valid, alu_in_a, alu_in_b, alu_control_out,
           rd_out, reg_write_out
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, pc, imm,
           sel_a_pc, sel_b_imm, alu_control_in, rd_in, reg_write_in,
           ex_mem_rd, mem_wb_rd, ex_mem_reg_write, mem_wb_reg_write,
           ex_mem_is_load, ex_mem_result, mem_wb_result, flush, out_ready,
    output in_ready, out_valid, alu_in_a, alu_in_b, alu_control_out,
           rd_out, reg_write_out
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: selects ALU operand sources, applies EX/MEM and
// MEM/WB forwarding, masks shift amounts and registers the result behind a
// valid/ready handshake with load-use stall and flush. The registered
// outputs feed the ALU inputs directly, so an empty stage presents a
// bubble code that makes the ALU produce 0.
module id_ex_operand_stage #(
  parameter int         XLEN        = 32,
  parameter int         REG_ADDR_W  = 5,
  parameter logic [3:0] BUBBLE_CTRL = 4'b1111
) (
  input logic                clk,
  input logic                rst,
  id_ex_operand_stage_if.slave bus
);

  localparam logic [3:0] CTRL_SLL = 4'b0011;
  localparam logic [3:0] CTRL_SRL = 4'b0101;
  localparam logic [3:0] CTRL_SRA = 4'b1001;

  // Registered stage contents
  logic                  valid_q;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [3:0]            ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  rw_q;

  // Forwarding match terms; a load in EX/MEM has no data yet, so it never
  // forwards and is handled by the stall instead.
  logic rs1_ex_hit, rs1_wb_hit, rs2_ex_hit, rs2_wb_hit;
  assign rs1_ex_hit = bus.ex_mem_reg_write && !bus.ex_mem_is_load &&
                      (bus.ex_mem_rd == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign rs1_wb_hit = bus.mem_wb_reg_write &&
                      (bus.mem_wb_rd == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign rs2_ex_hit = bus.ex_mem_reg_write && !bus.ex_mem_is_load &&
                      (bus.ex_mem_rd == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign rs2_wb_hit = bus.mem_wb_reg_write &&
                      (bus.mem_wb_rd == bus.rs2_addr) && (bus.rs2_addr != '0);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Resolve each source: newest producer first, x0 is hard-wired to zero
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rs1_fwd = bus.rs1_data;
    rs2_fwd = bus.rs2_data;
    if (bus.rs1_addr == '0)  rs1_fwd = '0;
    else if (rs1_ex_hit)     rs1_fwd = bus.ex_mem_result;
    else if (rs1_wb_hit)     rs1_fwd = bus.mem_wb_result;
    if (bus.rs2_addr == '0)  rs2_fwd = '0;
    else if (rs2_ex_hit)     rs2_fwd = bus.ex_mem_result;
    else if (rs2_wb_hit)     rs2_fwd = bus.mem_wb_result;
  end

  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b_raw;
  logic [XLEN-1:0] operand_b;
  logic            is_shift;

  assign operand_a     = bus.sel_a_pc  ? bus.pc  : rs1_fwd;
  assign operand_b_raw = bus.sel_b_imm ? bus.imm : rs2_fwd;
  assign is_shift      = (bus.alu_control_in == CTRL_SLL) ||
                         (bus.alu_control_in == CTRL_SRL) ||
                         (bus.alu_control_in == CTRL_SRA);
  // Shift amounts only use the low five bits; clear the rest so the ALU
  // never sees an out-of-range amount.
  assign operand_b     = is_shift ? {{(XLEN-5){1'b0}}, operand_b_raw[4:0]}
                                  : operand_b_raw;

  // Load-use hazard: only sources the instruction actually reads can stall
  logic hazard;
  assign hazard = bus.ex_mem_is_load && bus.ex_mem_reg_write &&
                  (bus.ex_mem_rd != '0) &&
                  ((!bus.sel_a_pc  && (bus.ex_mem_rd == bus.rs1_addr)) ||
                   (!bus.sel_b_imm && (bus.ex_mem_rd == bus.rs2_addr)));

  logic capture;
  assign bus.in_ready = !hazard && (!valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  // ID/EX register: flush beats capture beats consume beats hold
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else if (bus.flush || (!capture && valid_q && bus.out_ready)) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      a_q     <= operand_a;
      b_q     <= operand_b;
      ctrl_q  <= bus.alu_control_in;
      rd_q    <= bus.rd_in;
      rw_q    <= bus.reg_write_in;
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.alu_in_a        = a_q;
  assign bus.alu_in_b        = b_q;
  assign bus.alu_control_out = ctrl_q;
  assign bus.rd_out          = rd_q;
  assign bus.reg_write_out   = rw_q && valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage. Expected results are pushed
// to a scoreboard when the stage accepts an instruction and compared when
// the ALU side consumes it; scenario tasks add direct checks of handshake,
// stall, flush and reset behaviour.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(
    .XLEN(32), .REG_ADDR_W(5), .BUBBLE_CTRL(4'b1111)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   accepted;
  int   checks = 0;
  int   passed = 0;

  task automatic idle();
    bus.in_valid         = 1'b0;
    bus.rs1_addr         = '0;
    bus.rs2_addr         = '0;
    bus.rs1_data         = '0;
    bus.rs2_data         = '0;
    bus.pc               = 32'h0000_1000;
    bus.imm              = '0;
    bus.sel_a_pc         = 1'b0;
    bus.sel_b_imm        = 1'b0;
    bus.alu_control_in   = 4'b0000;
    bus.rd_in            = '0;
    bus.reg_write_in     = 1'b0;
    bus.ex_mem_rd        = '0;
    bus.mem_wb_rd        = '0;
    bus.ex_mem_reg_write = 1'b0;
    bus.mem_wb_reg_write = 1'b0;
    bus.ex_mem_is_load   = 1'b0;
    bus.ex_mem_result    = '0;
    bus.mem_wb_result    = '0;
    bus.flush            = 1'b0;
    bus.out_ready        = 1'b1;
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // One cycle: called at a falling edge with inputs already driven.
  task automatic step();
    exp_t e;
    #1;
    accepted = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output: a=%h b=%h with empty scoreboard",
                 bus.alu_in_a, bus.alu_in_b);
      end else begin
        e = q.pop_front();
        if ({bus.alu_in_a, bus.alu_in_b, bus.alu_control_out, bus.rd_out,
             bus.reg_write_out} !== e)
          $display("FAIL consume: got a=%h b=%h ctrl=%b rd=%0d rw=%b expected a=%h b=%h ctrl=%b rd=%0d rw=%b",
                   bus.alu_in_a, bus.alu_in_b, bus.alu_control_out, bus.rd_out,
                   bus.reg_write_out, e.a, e.b, e.ctrl, e.rd, e.rw);
        else passed++;
      end
    end else if (bus.flush && bus.out_valid && q.size() > 0) begin
      void'(q.pop_front());
    end
    if (bus.in_valid && bus.in_ready && !bus.flush) begin
      q.push_back(pend);
      accepted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2,
                         input logic sa, input logic sb, input logic [31:0] im,
                         input logic [3:0] ctrl, input logic [4:0] rd,
                         input logic [31:0] ea, input logic [31:0] eb);
    bus.in_valid       = 1'b1;
    bus.rs1_addr       = r1;
    bus.rs1_data       = d1;
    bus.rs2_addr       = r2;
    bus.rs2_data       = d2;
    bus.sel_a_pc       = sa;
    bus.sel_b_imm      = sb;
    bus.imm            = im;
    bus.alu_control_in = ctrl;
    bus.rd_in          = rd;
    bus.reg_write_in   = 1'b1;
    pend = '{a: ea, b: eb, ctrl: ctrl, rd: rd, rw: 1'b1};
  endtask

  // Present and wait (bounded) until the stage accepts it.
  task automatic issue(input string name,
                       input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic sa, input logic sb, input logic [31:0] im,
                       input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic [31:0] ea, input logic [31:0] eb);
    bit got = 1'b0;
    present(r1, d1, r2, d2, sa, sb, im, ctrl, rd, ea, eb);
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      got = accepted;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!got) $display("FAIL %s_accept: not accepted within 10 cycles", name);
    else passed++;
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && q.size() > 0; n++) step();
    check1("drain_empty", q.size(), 0);
  endtask

  task automatic test_reset();
    check1("reset_out_valid", bus.out_valid, 0);
    check1("reset_alu_in_a", bus.alu_in_a, 0);
    check1("reset_alu_in_b", bus.alu_in_b, 0);
    check1("reset_rd_out", bus.rd_out, 0);
    check1("reset_reg_write_out", bus.reg_write_out, 0);
    check1("reset_ctrl", bus.alu_control_out, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue("basic", 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b0, 32'h0, 4'b0010, 5'd5,
          32'h10, 32'h20);
    check1("basic_latency_valid", bus.out_valid, 1);
    drain();
    check1("basic_empty_ctrl", bus.alu_control_out, 4'b1111);
  endtask

  task automatic test_forwarding();
    bus.ex_mem_rd = 5'd3;  bus.ex_mem_reg_write = 1'b1; bus.ex_mem_result = 32'hAA;
    bus.mem_wb_rd = 5'd3;  bus.mem_wb_reg_write = 1'b1; bus.mem_wb_result = 32'hBB;
    issue("fwd_ex_priority", 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b0, 32'h0,
          4'b0000, 5'd6, 32'hAA, 32'h20);
    issue("fwd_x0", 5'd0, 32'h55, 5'd4, 32'h20, 1'b0, 1'b0, 32'h0,
          4'b0000, 5'd6, 32'h0, 32'h20);
    drain();
    bus.ex_mem_reg_write = 1'b0;
    issue("fwd_mem_wb", 5'd3, 32'h10, 5'd3, 32'h20, 1'b0, 1'b0, 32'h0,
          4'b0000, 5'd7, 32'hBB, 32'hBB);
    drain();
    bus.mem_wb_reg_write = 1'b0;
  endtask

  task automatic test_load_use();
    bus.ex_mem_rd = 5'd4; bus.ex_mem_reg_write = 1'b1;
    bus.ex_mem_is_load = 1'b1; bus.ex_mem_result = 32'h77;
    present(5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b0, 32'h0, 4'b0000, 5'd8,
            32'h10, 32'h77);
    #1;
    check1("load_use_in_ready", bus.in_ready, 0);
    step();
    step();
    check1("load_use_no_capture", bus.out_valid, 0);
    bus.ex_mem_is_load = 1'b0;
    issue("load_use_release", 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b0, 32'h0,
          4'b0000, 5'd8, 32'h10, 32'h77);
    drain();
    bus.ex_mem_is_load = 1'b1;
    present(5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b1, 32'h44, 4'b0000, 5'd8,
            32'h10, 32'h44);
    #1;
    check1("load_imm_no_stall", bus.in_ready, 1);
    issue("load_imm", 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 1'b1, 32'h44,
          4'b0000, 5'd8, 32'h10, 32'h44);
    drain();
    bus.ex_mem_is_load = 1'b0; bus.ex_mem_reg_write = 1'b0;
  endtask

  task automatic test_shift();
    issue("shift_sll", 5'd1, 32'h9, 5'd2, 32'h0, 1'b0, 1'b1, 32'h0000_0123,
          4'b0011, 5'd9, 32'h9, 32'h3);
    issue("shift_srl", 5'd1, 32'h9, 5'd2, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFE7,
          4'b0101, 5'd9, 32'h0000_1000, 32'h7);
    issue("shift_sra_reg", 5'd1, 32'h9, 5'd2, 32'h0000_003F, 1'b0, 1'b0, 32'h0,
          4'b1001, 5'd9, 32'h9, 32'h1F);
    issue("no_shift", 5'd1, 32'h9, 5'd2, 32'h0, 1'b0, 1'b1, 32'h0000_0123,
          4'b0010, 5'd9, 32'h9, 32'h123);
    drain();
  endtask

  task automatic test_stall_flush();
    bus.out_ready = 1'b0;
    issue("stall_fill", 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 1'b0, 32'h0,
          4'b0000, 5'd7, 32'h1, 32'h2);
    present(5'd1, 32'hEE, 5'd2, 32'hFF, 1'b0, 1'b0, 32'h0, 4'b0110, 5'd11,
            32'hEE, 32'hFF);
    for (int c = 0; c < 3; c++) begin
      #1;
      check1("stall_valid", bus.out_valid, 1);
      check1("stall_a", bus.alu_in_a, 32'h1);
      check1("stall_b", bus.alu_in_b, 32'h2);
      check1("stall_ctrl", bus.alu_control_out, 4'b0000);
      check1("stall_rd", bus.rd_out, 7);
      check1("stall_in_ready", bus.in_ready, 0);
      step();
    end
    bus.flush = 1'b1;
    step();
    check1("flush_valid", bus.out_valid, 0);
    check1("flush_ctrl", bus.alu_control_out, 4'b1111);
    check1("flush_reg_write", bus.reg_write_out, 0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    check1("flush_no_capture", bus.out_valid, 0);
    check1("flush_scoreboard", q.size(), 0);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(5'd1, 32'h100 + i, 5'd2, 32'h0, 1'b0, 1'b1, i, 4'b0000,
              5'(i + 1), 32'h100 + i, i);
      step();
      check1("b2b_accept", accepted, 1);
      check1("b2b_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    step();
    check1("b2b_done_valid", bus.out_valid, 0);
    check1("b2b_scoreboard", q.size(), 0);
  endtask

  task automatic test_reset_mid_stream();
    present(5'd1, 32'h321, 5'd2, 32'h0, 1'b0, 1'b1, 32'h5, 4'b0100, 5'd12,
            32'h321, 32'h5);
    step();
    check1("mid_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check1("mid_rst_valid", bus.out_valid, 0);
    check1("mid_rst_a", bus.alu_in_a, 0);
    check1("mid_rst_b", bus.alu_in_b, 0);
    check1("mid_rst_ctrl", bus.alu_control_out, 4'b1111);
    check1("mid_rst_reg_write", bus.reg_write_out, 0);
    q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check1("post_rst_valid", bus.out_valid, 0);
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_forwarding();
    test_load_use();
    test_shift();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Registered operand-delivery stage between decode and the ALU.
- Selects ALU operand sources (register/PC, register/immediate) and applies EX/MEM and MEM/WB forwarding.
- Masks shift amounts and holds the result in an ID/EX register with a valid/ready handshake, stall and flush.
- Its registered outputs drive the ALU's in_a, in_b and alu_control inputs directly.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- BUBBLE_CTRL, 4'b1111, ALU control code driven when the stage is empty; an unused code, so the ALU outputs 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- rs1_addr, rs2_addr  input  REG_ADDR_W  source indices.
- rs1_data, rs2_data  input  XLEN  register-file read data.
- pc  input  XLEN  instruction PC.
- imm  input  XLEN  sign-extended immediate.
- sel_a_pc  input  1  1: operand A = pc; 0: forwarded rs1.
- sel_b_imm  input  1  1: operand B = imm; 0: forwarded rs2.
- alu_control_in  input  4  ALU operation code.
- rd_in  input  REG_ADDR_W  destination index.
- reg_write_in  input  1  instruction writes rd.
- ex_mem_rd, mem_wb_rd  input  REG_ADDR_W  downstream destinations.
- ex_mem_reg_write, mem_wb_reg_write  input  1  downstream write enables.
- ex_mem_is_load  input  1  EX/MEM instruction is a load (its data is not yet available).
- ex_mem_result, mem_wb_result  input  XLEN  forwarding data.
- flush  input  1  kill the stage contents and the incoming instruction.
- out_valid  output  1  registered operands valid.
- out_ready  input  1  downstream consumes this cycle.
- alu_in_a, alu_in_b  output  XLEN  registered ALU operands.
- alu_control_out  output  4  registered ALU code.
- rd_out  output  REG_ADDR_W  registered destination.
- reg_write_out  output  1  registered write enable; forced 0 when out_valid = 0.

Behaviour:
- Reset (asynchronous, rst = 1):
  - out_valid = 0, alu_in_a = 0, alu_in_b = 0, rd_out = 0, reg_write_out = 0.
  - alu_control_out = BUBBLE_CTRL.
  - Reset mid-operation discards the held instruction immediately.
- Forwarding (combinational, per source rsN):
  - Priority 1: if ex_mem_reg_write, ex_mem_rd == rsN, rsN != 0 and !ex_mem_is_load, use ex_mem_result.
  - Priority 2: else if mem_wb_reg_write, mem_wb_rd == rsN and rsN != 0, use mem_wb_result.
  - Otherwise use rsN_data.
  - Index 0 always yields 0, regardless of rs1_data / rs2_data.
- Load-use hazard:
  - Raised when ex_mem_is_load, ex_mem_reg_write, ex_mem_rd != 0 and ex_mem_rd equals a source the instruction actually uses.
  - rs1 is used when sel_a_pc = 0; rs2 is used when sel_b_imm = 0.
  - While the hazard is raised, in_ready = 0.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - Capture occurs when in_valid && in_ready && !flush.
  - out_valid holds and all outputs stay stable while out_valid && !out_ready.
  - Capture and consume in the same cycle are allowed: throughput is 1 per cycle and latency is 1 cycle.
  - If out_valid && out_ready with no capture, the next state is empty: out_valid = 0, alu_control_out = BUBBLE_CTRL, reg_write_out = 0.
- Shift masking:
  - When alu_control_in is 4'b0011, 4'b0101 or 4'b1001, alu_in_b = {0, B[4:0]}.
  - All other codes pass B unmodified.
- Flush:
  - Next state is empty; the incoming instruction is not captured.
  - Flush wins over simultaneous capture and over out_ready = 0.
- Width rule: all operands are XLEN bits; no extension is performed here.

Test Plan:
- Reset, then in_valid = 1 with rs1 = 3 (data 0x10), rs2 = 4 (data 0x20), ctrl = 0010, no forwarding -> next cycle out_valid = 1, alu_in_a = 0x10, alu_in_b = 0x20, ctrl = 0010.
- ex_mem_rd = 3 and mem_wb_rd = 3 (both writing), ex_mem_result = 0xAA, mem_wb_result = 0xBB -> alu_in_a = 0xAA. Repeat with rs1 = 0 and rs1_data = 0x55 -> alu_in_a = 0.
- ex_mem_is_load = 1, ex_mem_rd = 4, instruction uses rs2 = 4 -> in_ready = 0 and no capture. Drop ex_mem_is_load -> capture with alu_in_b = ex_mem_result. Same case with sel_b_imm = 1 -> no stall.
- ctrl = 0011, B = 0x0000_0123 -> alu_in_b = 0x0000_0003. ctrl = 0010 with the same B -> alu_in_b = 0x123.
- out_valid = 1 with out_ready = 0 for 3 cycles -> outputs stable and in_ready = 0. Then assert flush with in_valid = 1 -> out_valid = 0, ctrl = 1111, reg_write_out = 0.
- Back-to-back stream of 4 instructions with out_ready = 1 -> one output per cycle, in order. Assert rst mid-stream -> outputs return to reset values immediately.
